// File: rtl/color_ratio_divider.sv
// Multi-channel colour normaliser: ratio[i] = floor(color[i]*SCALE/clear), clipped to SCALE.
// One shared restoring divider walks the channels in turn; results are published together on done.
module color_ratio_divider #(
  parameter int WIDTH    = 15,
  parameter int CHANNELS = 3,
  parameter int SCALE    = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [CHANNELS*WIDTH-1:0] color_in,
  input  logic [WIDTH-1:0]          clear_in,
  output logic                      busy,
  output logic                      done,
  output logic [CHANNELS*WIDTH-1:0] ratio_out,
  output logic [CHANNELS-1:0]       sat,
  output logic                      div_zero
);

  localparam int SW = $clog2(SCALE + 1);
  localparam int NW = WIDTH + SW;
  localparam int CW = $clog2(NW);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_STORE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [CHANNELS*WIDTH-1:0] r_color;
  logic [WIDTH-1:0]          r_clear;
  logic [IW-1:0]             r_idx;
  logic [NW-1:0]             r_num;
  logic [WIDTH:0]            r_rem;
  logic [NW-1:0]             r_quot;
  logic [CW-1:0]             r_bitCnt;
  logic [CHANNELS*WIDTH-1:0] r_stagedRatio;
  logic [CHANNELS-1:0]       r_stagedSat;
  logic                      r_busy;
  logic                      r_done;
  logic [CHANNELS*WIDTH-1:0] r_ratio;
  logic [CHANNELS-1:0]       r_sat;
  logic                      r_divZero;

  logic [WIDTH-1:0]          w_colorCh;
  logic                      w_clearZero;
  logic                      w_lastIdx;
  logic [WIDTH:0]            w_remShift;
  logic [WIDTH:0]            w_remSub;
  logic                      w_geq;
  logic                      w_quotSat;
  logic [WIDTH-1:0]          w_lane;
  logic [CHANNELS*WIDTH-1:0] w_stagedRatioNext;
  logic [CHANNELS-1:0]       w_stagedSatNext;

  assign busy      = r_busy;
  assign done      = r_done;
  assign ratio_out = r_ratio;
  assign sat       = r_sat;
  assign div_zero  = r_divZero;

  assign w_colorCh   = r_color[int'(r_idx)*WIDTH +: WIDTH];
  assign w_clearZero = (r_clear == '0);
  assign w_lastIdx   = (r_idx == IW'(CHANNELS - 1));

  // Remainder never reaches the divisor, so the shifted value fits in WIDTH+1 bits.
  assign w_remShift = {r_rem[WIDTH-1:0], r_num[NW-1]};
  assign w_geq      = (w_remShift >= {1'b0, r_clear});
  assign w_remSub   = w_remShift - {1'b0, r_clear};

  assign w_quotSat = (r_quot > NW'(SCALE));
  assign w_lane    = w_quotSat ? WIDTH'(SCALE) : r_quot[WIDTH-1:0];

  always_comb begin
    w_stagedRatioNext = r_stagedRatio;
    w_stagedSatNext   = r_stagedSat;
    w_stagedRatioNext[int'(r_idx)*WIDTH +: WIDTH] = w_lane;
    w_stagedSatNext[r_idx] = w_quotSat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_LOAD;
      S_LOAD:  w_nextState = w_clearZero ? S_STORE : S_DIV;
      S_DIV:   if (r_bitCnt == '0) w_nextState = S_STORE;
      S_STORE: w_nextState = w_lastIdx ? S_DONE : S_LOAD;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_color       <= '0;
      r_clear       <= '0;
      r_idx         <= '0;
      r_num         <= '0;
      r_rem         <= '0;
      r_quot        <= '0;
      r_bitCnt      <= '0;
      r_stagedRatio <= '0;
      r_stagedSat   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ratio       <= '0;
      r_sat         <= '0;
      r_divZero     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_color       <= color_in;
            r_clear       <= clear_in;
            r_idx         <= '0;
            r_stagedRatio <= '0;
            r_stagedSat   <= '0;
            r_busy        <= 1'b1;
          end
        end
        S_LOAD: begin
          r_num    <= NW'(w_colorCh) * NW'(SCALE);
          r_rem    <= '0;
          r_quot   <= '0;
          r_bitCnt <= CW'(NW - 1);
        end
        S_DIV: begin
          r_rem    <= w_geq ? w_remSub : w_remShift;
          r_quot   <= {r_quot[NW-2:0], w_geq};
          r_num    <= {r_num[NW-2:0], 1'b0};
          r_bitCnt <= r_bitCnt - 1'b1;
        end
        S_STORE: begin
          r_stagedRatio <= w_stagedRatioNext;
          r_stagedSat   <= w_stagedSatNext;
          // Publishing on the final store edge makes the outputs valid during the done cycle.
          if (w_lastIdx) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_ratio   <= w_stagedRatioNext;
            r_sat     <= w_stagedSatNext;
            r_divZero <= w_clearZero;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_ratio_divider.sv
// Randomised and directed bench for color_ratio_divider against an arithmetic reference model.
module tb_color_ratio_divider;

  localparam int WIDTH    = 15;
  localparam int CHANNELS = 3;
  localparam int SCALE    = 255;
  localparam int NW       = WIDTH + $clog2(SCALE + 1);
  localparam int LAT_DIV  = CHANNELS * (NW + 2);
  localparam int LAT_ZERO = CHANNELS * 2;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      start;
  logic [CHANNELS*WIDTH-1:0] color_in;
  logic [WIDTH-1:0]          clear_in;
  logic                      busy;
  logic                      done;
  logic [CHANNELS*WIDTH-1:0] ratio_out;
  logic [CHANNELS-1:0]       sat;
  logic                      div_zero;

  int nTests = 0;
  int nFail  = 0;

  color_ratio_divider #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SCALE(SCALE)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .color_in(color_in),
    .clear_in(clear_in),
    .busy(busy),
    .done(done),
    .ratio_out(ratio_out),
    .sat(sat),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    nTests++;
    if (observed !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: exact quotient, clipped to SCALE; a zero divisor forces zero.
  function automatic longint modelRatio(input longint c, input longint clr);
    longint q;
    if (clr == 0) return 0;
    q = (c * SCALE) / clr;
    return (q > SCALE) ? SCALE : q;
  endfunction

  function automatic longint modelSat(input longint c, input longint clr);
    if (clr == 0) return 0;
    return (((c * SCALE) / clr) > SCALE) ? 1 : 0;
  endfunction

  task automatic waitDone(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 400) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("done_seen", longint'(done), 1);
  endtask

  task automatic checkResults(input string tag, input logic [WIDTH-1:0] c0, c1, c2,
                              input logic [WIDTH-1:0] clr);
    logic [WIDTH-1:0] cs [CHANNELS];
    cs[0] = c0;
    cs[1] = c1;
    cs[2] = c2;
    for (int i = 0; i < CHANNELS; i++) begin
      checkOutput($sformatf("%s_ratio%0d", tag, i), longint'(ratio_out[i*WIDTH +: WIDTH]),
                  modelRatio(longint'(cs[i]), longint'(clr)));
      checkOutput($sformatf("%s_sat%0d", tag, i), longint'(sat[i]),
                  modelSat(longint'(cs[i]), longint'(clr)));
    end
    checkOutput({tag, "_divzero"}, longint'(div_zero), (clr == 0) ? 1 : 0);
  endtask

  task automatic launch(input logic [WIDTH-1:0] c0, c1, c2, input logic [WIDTH-1:0] clr);
    @(negedge clk);
    color_in = {c2, c1, c0};
    clear_in = clr;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    color_in = (CHANNELS*WIDTH)'({$urandom(), $urandom()});
    clear_in = WIDTH'($urandom());
  endtask

  task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] c0, c1, c2,
                               input logic [WIDTH-1:0] clr);
    int edges;
    launch(c0, c1, c2, clr);
    checkOutput({tag, "_busy"}, longint'(busy), 1);
    waitDone(edges);
    checkOutput({tag, "_latency"}, edges, (clr == 0) ? LAT_ZERO : LAT_DIV);
    checkOutput({tag, "_busy_at_done"}, longint'(busy), 0);
    checkResults(tag, c0, c1, c2, clr);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, longint'(done), 0);
    checkResults({tag, "_hold"}, c0, c1, c2, clr);
  endtask

  typedef struct {
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] c0;
  } sweep_t;

  initial begin
    sweep_t sweep [6];
    int edges;
    int extra;
    logic [WIDTH-1:0] rc0, rc1, rc2, rclr;

    reset_n  = 1'b0;
    start    = 1'b0;
    color_in = '0;
    clear_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", longint'(busy), 0);
    checkOutput("reset_done", longint'(done), 0);
    checkOutput("reset_ratio", longint'(ratio_out), 0);
    checkOutput("reset_sat", longint'(sat), 0);
    checkOutput("reset_divzero", longint'(div_zero), 0);
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus("basic", 15'd100, 15'd200, 15'd90, 15'd130);

    sweep = '{'{15'd130, 15'd100}, '{15'd215, 15'd200}, '{15'd120, 15'd90},
              '{15'd89, 15'd70}, '{15'd173, 15'd16}, '{15'd294, 15'd255}};
    foreach (sweep[i])
      applyStimulus($sformatf("sweep%0d", i), sweep[i].c0, 15'd0, 15'd0, sweep[i].clr);

    applyStimulus("divzero", 15'd5, 15'd0, 15'd32767, 15'd0);
    applyStimulus("clear1", 15'd0, 15'd1, 15'd2, 15'd1);
    applyStimulus("extreme", 15'd32767, 15'd1, 15'd0, 15'd32767);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: begin
          rclr = WIDTH'($urandom());
          rc0 = WIDTH'($urandom()); rc1 = WIDTH'($urandom()); rc2 = WIDTH'($urandom());
        end
        1: begin
          rclr = WIDTH'($urandom_range(1, 300));
          rc0 = WIDTH'($urandom_range(0, 600));
          rc1 = WIDTH'($urandom_range(0, 600));
          rc2 = WIDTH'($urandom_range(0, 600));
        end
        2: begin
          rclr = '0;
          rc0 = WIDTH'($urandom()); rc1 = WIDTH'($urandom()); rc2 = WIDTH'($urandom());
        end
        default: begin
          rclr = WIDTH'($urandom_range(2, 32000));
          rc0 = rclr; rc1 = rclr - 1'b1; rc2 = rclr + 1'b1;
        end
      endcase
      applyStimulus($sformatf("rand%0d", n), rc0, rc1, rc2, rclr);
    end

    // A start during the run and another in the done cycle must both be dropped.
    launch(15'd100, 15'd200, 15'd90, 15'd130);
    edges = 0;
    while (done !== 1'b1 && edges < 400) begin
      @(negedge clk);
      edges++;
      start = (edges == 10);
      if (edges == 10) begin
        color_in = {15'd7, 15'd7, 15'd7};
        clear_in = 15'd0;
      end
    end
    checkOutput("ignore_done_seen", longint'(done), 1);
    checkOutput("ignore_latency", edges, LAT_DIV);
    checkResults("ignore_first", 15'd100, 15'd200, 15'd90, 15'd130);
    color_in = {15'd7, 15'd7, 15'd7};
    clear_in = 15'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignore_busy", longint'(busy), 0);
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checkOutput("ignore_extra_done", extra, 0);
    checkResults("ignore_hold", 15'd100, 15'd200, 15'd90, 15'd130);

    // Reset partway through a request discards it entirely.
    launch(15'd1000, 15'd2000, 15'd3000, 15'd4000);
    edges = 0;
    while (edges < 40) begin
      @(negedge clk);
      edges++;
    end
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_busy", longint'(busy), 0);
    checkOutput("midreset_done", longint'(done), 0);
    checkOutput("midreset_ratio", longint'(ratio_out), 0);
    checkOutput("midreset_sat", longint'(sat), 0);
    @(negedge clk);
    reset_n = 1'b1;
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checkOutput("midreset_no_done", extra, 0);
    checkOutput("midreset_ratio_hold", longint'(ratio_out), 0);
    applyStimulus("after_reset", 15'd70, 15'd16, 15'd255, 15'd89);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
